// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core front end.
//   PC_W          : width of a byte program counter
//   IROM_ADDR_W   : default instruction-ROM word-address width
//   NOP_INST      : encoding used for an empty IF/ID instruction slot
//   fetch_state_e : fetch FSM states (FS_RUN normal, FS_ERR trapped)
//   addr_in_range : word-aligned and inside a ROM of 2**aw words.
//                   The data-memory side uses the same check.
package cpu_pkg;

  localparam int PC_W        = 32;
  localparam int IROM_ADDR_W = 16;

  localparam logic [PC_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [0:0] {
    FS_RUN = 1'b0,
    FS_ERR = 1'b1
  } fetch_state_e;

  // True when addr is word-aligned and every bit above the word index is zero.
  function automatic logic addr_in_range(input logic [PC_W-1:0] addr,
                                         input int unsigned    aw);
    logic [PC_W-1:0] hi;
    hi = addr >> (aw + 32'd2);
    return (addr[1:0] == 2'b00) && (hi == '0);
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-side bus bundle: the instruction-ROM read port plus the IF/ID
// output handshake toward decode.
//   irom_addr    : ROM word address (fetch -> ROM), combinational
//   irom_inst    : ROM read data, same cycle (ROM -> fetch)
//   out_valid    : IF/ID entry valid (fetch -> decode)
//   out_ready    : decode accepts the entry (decode -> fetch)
//   out_pc       : byte PC of out_inst
//   out_pc_plus4 : out_pc + 4
//   out_inst     : fetched instruction
//
// Handshake: an entry transfers on a rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the payload is
// held stable. out_valid does not depend combinationally on out_ready.
// A redirect may withdraw a valid entry without a transfer.
interface ifetch_unit_if #(
  parameter int ADDR_W = cpu_pkg::IROM_ADDR_W
);

  logic [ADDR_W-1:0] irom_addr;
  logic [31:0]       irom_inst;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_pc_plus4;
  logic [31:0]       out_inst;

  // Fetch unit side.
  modport master (
    output irom_addr,
    input  irom_inst,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_pc_plus4,
    output out_inst
  );

  // ROM + decode side.
  modport slave (
    input  irom_addr,
    output irom_inst,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_pc_plus4,
    input  out_inst
  );

endinterface

// File: rtl/ifetch_unit_ifid_reg.sv
// IF/ID holding register with valid/ready.
//   clk, rst_n    : clock, synchronous active-low reset
//   kill          : drop the held entry (payload registers keep their values)
//   load          : capture in_* as a new valid entry
//   ready         : downstream accepts the held entry this cycle
//   in_*          : payload to capture
//   valid, out_*  : registered entry
// Priority per edge: kill, then load, then consume.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kill,
  input  logic        load,
  input  logic        ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_pc_plus4,
  input  logic [31:0] in_inst,
  output logic        valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic [31:0] out_inst
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid        <= 1'b0;
      out_pc       <= '0;
      out_pc_plus4 <= '0;
      out_inst     <= NOP_INST;
    end else if (kill) begin
      valid <= 1'b0;
    end else if (load) begin
      valid        <= 1'b1;
      out_pc       <= in_pc;
      out_pc_plus4 <= in_pc_plus4;
      out_inst     <= in_inst;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch unit: owns the PC, reads the combinational ROM and fills
// the IF/ID register. Handles redirects, stalls and out-of-range/misaligned
// fetch traps.
//   clk, rst_n      : clock, synchronous active-low reset
//   fetch           : ROM port + IF/ID handshake (master modport)
//   stall           : no new fetch this cycle
//   redirect_valid  : taken branch/jump/flush
//   redirect_pc     : redirect byte target
//   fetch_err       : sticky fetch fault
//   fetch_count     : instructions captured into IF/ID (wraps)
//   dbg_state       : current fetch FSM state
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = IROM_ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  ifetch_unit_if.master fetch,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          fetch_err,
  output logic [31:0]   fetch_count,
  output fetch_state_e  dbg_state
);

  // Last legal byte address, computed in 33 bits so pc+4 cannot wrap past it.
  localparam logic [32:0] ROM_LAST = (33'd4 << ADDR_W) - 33'd4;

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         run;
  logic         free;
  logic         kill;
  logic         capture;
  logic         redirect_bad;
  logic         next_over;

  assign pc_plus4     = pc + 32'd4;
  assign run          = (state == FS_RUN);
  assign free         = !fetch.out_valid || fetch.out_ready;
  // A redirect kills the held entry even if decode is accepting it.
  assign kill         = run && redirect_valid;
  assign capture      = run && !redirect_valid && !stall && free;
  assign redirect_bad = !addr_in_range(redirect_pc, ADDR_W);
  assign next_over    = ({1'b0, pc} + 33'd4) > ROM_LAST;

  assign fetch.irom_addr = pc[ADDR_W+1:2];
  assign dbg_state       = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FS_RUN;
      pc          <= RESET_PC;
      fetch_err   <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        FS_RUN: begin
          if (redirect_valid) begin
            // The faulting target is kept in pc so irom_addr shows it.
            pc <= redirect_pc;
            if (redirect_bad) begin
              state     <= FS_ERR;
              fetch_err <= 1'b1;
            end
          end else if (capture) begin
            fetch_count <= fetch_count + 32'd1;
            // The last ROM word is still delivered; the fetch after it traps.
            if (next_over) begin
              state     <= FS_ERR;
              fetch_err <= 1'b1;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        FS_ERR: begin
          // Only reset leaves this state.
          state <= FS_ERR;
        end
        default: state <= FS_ERR;
      endcase
    end
  end

  ifid_reg u_ifid (
    .clk          (clk),
    .rst_n        (rst_n),
    .kill         (kill),
    .load         (capture),
    .ready        (fetch.out_ready),
    .in_pc        (pc),
    .in_pc_plus4  (pc_plus4),
    .in_inst      (fetch.irom_inst),
    .valid        (fetch.out_valid),
    .out_pc       (fetch.out_pc),
    .out_pc_plus4 (fetch.out_pc_plus4),
    .out_inst     (fetch.out_inst)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a per-cycle vector table on a 16-bit-ROM instance,
// a random backpressure run checked through an expected-entry queue, and an
// ADDR_W=4 instance run off the end of its ROM.
module tb_ifetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] BA = 32'h1000_0000;  // ROM A: word k = BA + k
  localparam logic [31:0] BB = 32'h2000_0000;  // ROM B: word k = BB + k

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, stall_a, rv_a;
  logic [31:0] rpc_a;
  logic        err_a;
  logic [31:0] count_a;
  fetch_state_e state_a;

  logic        rst_b_n, stall_b, rv_b;
  logic [31:0] rpc_b;
  logic        err_b;
  logic [31:0] count_b;
  fetch_state_e state_b;

  ifetch_unit_if #(.ADDR_W(16)) bus_a ();
  ifetch_unit_if #(.ADDR_W(4))  bus_b ();

  assign bus_a.irom_inst = BA + 32'(bus_a.irom_addr);
  assign bus_b.irom_inst = BB + 32'(bus_b.irom_addr);

  ifetch_unit #(.RESET_PC(32'h0), .ADDR_W(16)) dut_a (
    .clk            (clk),
    .rst_n          (rst_a_n),
    .fetch          (bus_a),
    .stall          (stall_a),
    .redirect_valid (rv_a),
    .redirect_pc    (rpc_a),
    .fetch_err      (err_a),
    .fetch_count    (count_a),
    .dbg_state      (state_a)
  );

  ifetch_unit #(.RESET_PC(32'h0), .ADDR_W(4)) dut_b (
    .clk            (clk),
    .rst_n          (rst_b_n),
    .fetch          (bus_b),
    .stall          (stall_b),
    .redirect_valid (rv_b),
    .redirect_pc    (rpc_b),
    .fetch_err      (err_b),
    .fetch_count    (count_b),
    .dbg_state      (state_b)
  );

  // ---------------- scoreboard / counters ----------------
  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];   // {pc, inst} of entries expected in order

  task automatic check32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input string name, input logic [31:0] pc,
                        input logic [31:0] inst);
    logic [63:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected entry pc=%h inst=%h", name, pc, inst);
    end else begin
      e = exp_q.pop_front();
      if ({pc, inst} !== e) begin
        errors++;
        $display("FAIL %s: got pc=%h inst=%h expected pc=%h inst=%h",
                 name, pc, inst, e[63:32], e[31:0]);
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_count;
    logic        exp_err;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic s, input logic rd,
                         input logic rv, input logic [31:0] rpc,
                         input logic v, input logic [31:0] pc,
                         input logic [31:0] inst, input logic [31:0] cnt,
                         input logic err, input logic [15:0] addr);
    vec_t t;
    t.rst_n = r; t.stall = s; t.ready = rd; t.rv = rv; t.rpc = rpc;
    t.exp_valid = v; t.exp_pc = pc; t.exp_inst = inst; t.exp_count = cnt;
    t.exp_err = err; t.exp_addr = addr;
    vecs.push_back(t);
  endtask

  task automatic check_a(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] pc4, input logic [31:0] inst,
                         input logic [31:0] cnt, input logic err,
                         input logic [15:0] addr);
    check32({tag, ".out_valid"},    32'(bus_a.out_valid), 32'(v));
    check32({tag, ".out_pc"},       bus_a.out_pc, pc);
    check32({tag, ".out_pc_plus4"}, bus_a.out_pc_plus4, pc4);
    check32({tag, ".out_inst"},     bus_a.out_inst, inst);
    check32({tag, ".fetch_count"},  count_a, cnt);
    check32({tag, ".fetch_err"},    32'(err_a), 32'(err));
    check32({tag, ".state"},        32'(state_a), err ? 32'(FS_ERR) : 32'(FS_RUN));
    check32({tag, ".irom_addr"},    32'(bus_a.irom_addr), 32'(addr));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int accepted;
    int b_entries;
    string tag;
    logic [31:0] pc4;

    rst_a_n = 1'b0; stall_a = 1'b0; rv_a = 1'b0; rpc_a = '0;
    rst_b_n = 1'b0; stall_b = 1'b0; rv_b = 1'b0; rpc_b = '0;
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;

    // Free run 0,4,8; backpressure at pc 8; redirect 0x100 under stall;
    // consume during stall; misaligned redirect; reset; reset while held.
    //      rst s rd rv rpc          v pc        inst     cnt err addr
    add_vec(1, 0, 1, 0, 32'h0,       1, 32'h0,   BA+0,    1,  0, 16'h1);
    add_vec(1, 0, 1, 0, 32'h0,       1, 32'h4,   BA+1,    2,  0, 16'h2);
    add_vec(1, 0, 1, 0, 32'h0,       1, 32'h8,   BA+2,    3,  0, 16'h3);
    add_vec(1, 0, 0, 0, 32'h0,       1, 32'h8,   BA+2,    3,  0, 16'h3);
    add_vec(1, 0, 0, 0, 32'h0,       1, 32'h8,   BA+2,    3,  0, 16'h3);
    add_vec(1, 0, 0, 0, 32'h0,       1, 32'h8,   BA+2,    3,  0, 16'h3);
    add_vec(1, 0, 1, 0, 32'h0,       1, 32'hC,   BA+3,    4,  0, 16'h4);
    add_vec(1, 1, 1, 1, 32'h100,     0, 32'hC,   BA+3,    4,  0, 16'h40);
    add_vec(1, 0, 1, 0, 32'h0,       1, 32'h100, BA+64,   5,  0, 16'h41);
    add_vec(1, 1, 1, 0, 32'h0,       0, 32'h100, BA+64,   5,  0, 16'h41);
    add_vec(1, 1, 0, 0, 32'h0,       0, 32'h100, BA+64,   5,  0, 16'h41);
    add_vec(1, 0, 0, 0, 32'h0,       1, 32'h104, BA+65,   6,  0, 16'h42);
    add_vec(1, 0, 1, 1, 32'h102,     0, 32'h104, BA+65,   6,  1, 16'h40);
    add_vec(1, 0, 1, 1, 32'h200,     0, 32'h104, BA+65,   6,  1, 16'h40);
    add_vec(1, 0, 1, 0, 32'h0,       0, 32'h104, BA+65,   6,  1, 16'h40);
    add_vec(0, 0, 1, 0, 32'h0,       0, 32'h0,   32'h0,   0,  0, 16'h0);
    add_vec(1, 0, 1, 0, 32'h0,       1, 32'h0,   BA+0,    1,  0, 16'h1);
    add_vec(1, 0, 1, 0, 32'h0,       1, 32'h4,   BA+1,    2,  0, 16'h2);
    add_vec(1, 0, 1, 0, 32'h0,       1, 32'h8,   BA+2,    3,  0, 16'h3);
    add_vec(1, 0, 1, 0, 32'h0,       1, 32'hC,   BA+3,    4,  0, 16'h4);
    add_vec(1, 0, 1, 0, 32'h0,       1, 32'h10,  BA+4,    5,  0, 16'h5);
    add_vec(1, 0, 0, 0, 32'h0,       1, 32'h10,  BA+4,    5,  0, 16'h5);
    add_vec(0, 0, 0, 0, 32'h0,       0, 32'h0,   32'h0,   0,  0, 16'h0);
    add_vec(1, 0, 1, 0, 32'h0,       1, 32'h0,   BA+0,    1,  0, 16'h1);

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    check_a("reset_a", 1'b0, 32'h0, 32'h0, NOP_INST, 32'h0, 1'b0, 16'h0);
    check32("reset_b.out_valid", 32'(bus_b.out_valid), 32'h0);
    check32("reset_b.fetch_err", 32'(err_b), 32'h0);

    // Table-driven cycles on instance A.
    for (int i = 0; i < vecs.size(); i++) begin
      rst_a_n         = vecs[i].rst_n;
      stall_a         = vecs[i].stall;
      bus_a.out_ready = vecs[i].ready;
      rv_a            = vecs[i].rv;
      rpc_a           = vecs[i].rpc;
      @(posedge clk);
      #1;
      pc4 = (vecs[i].exp_count == 0) ? 32'h0 : vecs[i].exp_pc + 32'd4;
      tag = $sformatf("vec%0d", i);
      check_a(tag, vecs[i].exp_valid, vecs[i].exp_pc, pc4, vecs[i].exp_inst,
              vecs[i].exp_count, vecs[i].exp_err, vecs[i].exp_addr);
    end

    // Random stall/backpressure on A: accepted entries must be 0,4,8,...
    rst_a_n = 1'b0; stall_a = 1'b0; rv_a = 1'b0; bus_a.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_a_n = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 256; k++) exp_q.push_back({32'(k * 4), BA + 32'(k)});
    accepted = 0;
    for (int c = 0; c < 200; c++) begin
      stall_a         = ($urandom_range(0, 3) == 0);
      bus_a.out_ready = ($urandom_range(0, 2) != 0);
      if (bus_a.out_valid && bus_a.out_ready) begin
        sb_pop("rand_a.entry", bus_a.out_pc, bus_a.out_inst);
        check32("rand_a.pc_plus4", bus_a.out_pc_plus4, bus_a.out_pc + 32'd4);
        accepted++;
      end
      @(posedge clk);
      #1;
    end
    bus_a.out_ready = 1'b0;
    check32("rand_a.fetch_count", count_a, 32'(accepted) + 32'(bus_a.out_valid));
    check32("rand_a.fetch_err", 32'(err_a), 32'h0);

    // ADDR_W=4: words 0x0..0x3C delivered, then trap with no entry for 0x40.
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back({32'(k * 4), BB + 32'(k)});
    rst_b_n = 1'b1;
    b_entries = 0;
    for (int e = 1; e <= 22; e++) begin
      @(posedge clk);
      #1;
      if (bus_b.out_valid) begin
        sb_pop("rom_end_b.entry", bus_b.out_pc, bus_b.out_inst);
        b_entries++;
      end
      if (e == 15) check32("rom_end_b.err_before", 32'(err_b), 32'h0);
      if (e == 16) begin
        check32("rom_end_b.last_valid", 32'(bus_b.out_valid), 32'h1);
        check32("rom_end_b.last_pc", bus_b.out_pc, 32'h3C);
        check32("rom_end_b.err_set", 32'(err_b), 32'h1);
      end
    end
    check32("rom_end_b.entries", 32'(b_entries), 32'd16);
    check32("rom_end_b.queue_left", 32'(exp_q.size()), 32'h0);
    check32("rom_end_b.out_valid", 32'(bus_b.out_valid), 32'h0);
    check32("rom_end_b.fetch_count", count_b, 32'd16);
    check32("rom_end_b.state", 32'(state_b), 32'(FS_ERR));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
